hazard_forward_unit: RTL
========================

Name: hazard_forward_unit

Overview:
- Decode-stage hazard and forwarding controller for the 5-stage RV32I pipeline.
- Keeps a shadow pipeline of destination-register records for the instructions in EX and MEM.
- Compares that shadow pipeline against the ID-stage source registers and drives the register file's forward_EN1/forward_EN2 one-hot selects.
- Raises a one-cycle load-use stall and counts stall cycles for debug.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- rs1  input  5  ID source register 1
- rs2  input  5  ID source register 2
- rs1_used  input  1  ID instruction reads rs1
- rs2_used  input  1  ID instruction reads rs2
- rd_ID  input  5  ID destination register
- reg_we_ID  input  1  ID instruction writes rd
- lui_ID  input  1  ID instruction is LUI (result = immediate)
- memread_ID  input  1  ID instruction is a load
- valid_ID  input  1  ID slot holds a real instruction
- flush  input  1  branch/jump taken; squash the ID instruction
- forward_EN1  output  6  rs1 forwarding select, one-hot or zero
- forward_EN2  output  6  rs2 forwarding select, one-hot or zero
- stall  output  1  hold PC and IF/ID; insert a bubble into EX
- stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst.
- Records: each EX and MEM record holds {valid, we, lui, load, rd, via_stall}.
- A record is "live" only when valid=1, we=1 and rd != 0.
- Posedge update, in order:
  - rst: both records cleared, stall_cnt=0.
  - flush=1 or stall=1: EX <= bubble (valid=0). MEM <= EX.
  - Otherwise: EX <= {valid_ID, reg_we_ID, lui_ID, memread_ID, rd_ID, 0}. MEM <= EX.
  - EX.via_stall is set when the previous cycle was a stall. It marks a load that entered MEM as a result of the stall.
  - WB is not tracked. The register file writes on negedge, so WB-stage data is already visible.
- Forwarding select (combinational), evaluated per source s ∈ {rs1, rs2} with its used flag:
  - s==0, or used flag=0: code 000000.
  - Else if live EX record with EX.rd==s:
    - lui → 100000 (imm_EX)
    - non-load → 001000 (aluout_EX)
    - load → 000000; the stall rule covers this case.
  - Else if live MEM record with MEM.rd==s:
    - lui → 010000 (imm_MEM)
    - load with via_stall=0 → 000010 (dataout_MEM)
    - load with via_stall=1 → 000001 (dataout_MEM)
    - otherwise → 000100 (aluout_MEM)
  - Else 000000 (register file value).
  - The EX match has priority over the MEM match (youngest producer wins).
  - At most one bit is set in each output.
- Stall (combinational):
  - stall=1 when valid_ID=1, flush=0, and a live EX record with load=1 matches a used non-zero rs1 or rs2.
  - Duration is exactly one cycle. On the next cycle the load is in MEM, its via_stall=1, and the code is 000001.
  - flush has priority over stall: with flush=1, stall=0 and a bubble is inserted.
- stall_cnt: increments on each posedge where stall=1; saturates at all-ones.
- Reset values: forward_EN1=forward_EN2=000000, stall=0, stall_cnt=0 in the cycle after rst.
- Reset mid-stall clears the records; stall drops the next cycle.
- A bubble record (valid=0) never forwards and never stalls, even if its rd field matches.
- x0 is never forwarded, regardless of producer records.

Test Plan:
- Reset behaviour: rst=1 for 2 cycles, then drive rs1=5 with rs1_used=1 and no producers → forward_EN1=000000, stall=0, stall_cnt=0.
- ALU forwarding: ADD x5 in ID, then ID reads rs1=5 and rs2=5 → forward_EN1=forward_EN2=001000. One cycle later, a new ID reads rs1=5 → 000100.
- LUI forwarding: LUI x7 followed by a reader of rs2=7 → forward_EN2=100000. The next reader of rs2=7 → 010000.
- Load-use: LW x9 followed immediately by a reader of rs1=9 → stall=1 for exactly one cycle and stall_cnt 0→1, then forward_EN1=000001. A reader placed one slot later (no stall) sees 000010.
- Priority and x0: ADD x3 then SUB x3, then ID reads rs1=3 → 001000 (from EX). ID reads rs1=0 after ADD x0 → 000000.
- Flush vs stall: LW x4 in EX, ID reads rs1=4, flush=1 → stall=0 and EX becomes a bubble. The next cycle has no forwarding from that ID instruction.
- Counter saturation: with CNT_W=2, apply 5 load-use stalls → stall_cnt=3.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard detection and forwarding select for the RV32I pipeline.
// Tracks destination records for EX and MEM and raises a one-cycle load-use stall.
module hazard_forward_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic             rs1_used,
   input  logic             rs2_used,
   input  logic [4:0]       rd_ID,
   input  logic             reg_we_ID,
   input  logic             lui_ID,
   input  logic             memread_ID,
   input  logic             valid_ID,
   input  logic             flush,
   output logic [5:0]       forward_EN1,
   output logic [5:0]       forward_EN2,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             ex_valid_q, ex_valid_d;
   logic             ex_we_q, ex_we_d;
   logic             ex_lui_q, ex_lui_d;
   logic             ex_load_q, ex_load_d;
   logic [4:0]       ex_rd_q, ex_rd_d;

   logic             mem_valid_q;
   logic             mem_we_q;
   logic             mem_lui_q;
   logic             mem_load_q;
   logic [4:0]       mem_rd_q;
   logic             mem_vs_q, mem_vs_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic ex_live;
   logic mem_live;
   logic hit1_ex, hit2_ex;

   assign ex_live  = ex_valid_q & ex_we_q & (ex_rd_q != 5'd0);
   assign mem_live = mem_valid_q & mem_we_q & (mem_rd_q != 5'd0);

   function automatic logic [5:0] fwd_sel(input logic [4:0] s,
                                          input logic       used);
      logic [5:0] r;
      r = 6'b000000;
      if (used && s != 5'd0) begin
         if (ex_live && ex_rd_q == s) begin
            if (ex_lui_q)        r = 6'b100000;
            else if (!ex_load_q) r = 6'b001000;
            else                 r = 6'b000000;
         end else if (mem_live && mem_rd_q == s) begin
            if (mem_lui_q)       r = 6'b010000;
            else if (mem_load_q) r = mem_vs_q ? 6'b000001 : 6'b000010;
            else                 r = 6'b000100;
         end
      end
      return r;
   endfunction

   assign forward_EN1 = fwd_sel(rs1, rs1_used);
   assign forward_EN2 = fwd_sel(rs2, rs2_used);

   assign hit1_ex = rs1_used & (rs1 != 5'd0) & (ex_rd_q == rs1);
   assign hit2_ex = rs2_used & (rs2 != 5'd0) & (ex_rd_q == rs2);
   assign stall   = valid_ID & ~flush & ex_live & ex_load_q
                  & (hit1_ex | hit2_ex);

   assign stall_cnt = cnt_q;

   always_comb begin
      ex_valid_d = valid_ID;
      ex_we_d    = reg_we_ID;
      ex_lui_d   = lui_ID;
      ex_load_d  = memread_ID;
      ex_rd_d    = rd_ID;
      // a load leaving EX while ID is held reaches MEM via the stall path
      mem_vs_d   = stall;
      if (flush || stall) begin
         ex_valid_d = 1'b0;
      end
      cnt_d = cnt_q;
      if (stall && cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q  <= 1'b0;
         ex_we_q     <= 1'b0;
         ex_lui_q    <= 1'b0;
         ex_load_q   <= 1'b0;
         ex_rd_q     <= 5'd0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_lui_q   <= 1'b0;
         mem_load_q  <= 1'b0;
         mem_rd_q    <= 5'd0;
         mem_vs_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_we_q     <= ex_we_d;
         ex_lui_q    <= ex_lui_d;
         ex_load_q   <= ex_load_d;
         ex_rd_q     <= ex_rd_d;
         mem_valid_q <= ex_valid_q;
         mem_we_q    <= ex_we_q;
         mem_lui_q   <= ex_lui_q;
         mem_load_q  <= ex_load_q;
         mem_rd_q    <= ex_rd_q;
         mem_vs_q    <= mem_vs_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule
